// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module : game_pkg
// Brief  : Shared types and constants for the ghost game datapath and control.
// Rev    : 1.0 - initial release
// ============================================================================
package game_pkg;

  localparam int COORD_W = 7;
  localparam int X_W     = 3;
  localparam int Y_W     = 4;

  // Coordinates are packed as {X[2:0], Y[3:0]}.
  localparam logic [COORD_W-1:0] START_COORD    = 7'b100_0100;
  localparam logic [COORD_W-1:0] SCORE_COORD_LO = 7'h0D;
  localparam logic [COORD_W-1:0] SCORE_COORD_HI = 7'h0F;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    DOWN  = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    OVER  = 2'b11
  } state_t;

  // Opposite headings share the axis bit and differ in the sign bit.
  function automatic logic is_reverse(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

  function automatic logic [COORD_W-1:0] move_coord(input logic [COORD_W-1:0] c,
                                                    input dir_t d);
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    x = c[COORD_W-1:Y_W];
    y = c[Y_W-1:0];
    case (d)
      UP:      y = y - Y_W'(1);
      DOWN:    y = y + Y_W'(1);
      LEFT:    x = x - X_W'(1);
      default: x = x + X_W'(1);
    endcase
    return {x, y};
  endfunction

  function automatic logic in_score_area(input logic [COORD_W-1:0] c);
    return (c >= SCORE_COORD_LO) && (c <= SCORE_COORD_HI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module : tick_prescaler
// Brief  : Divides clk by PRESCALE, one-cycle tick on the last count; holds when idle.
// Rev    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int PRESCALE = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int                C_CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(PRESCALE - 1);

  logic [C_CNT_W-1:0] r_pre_cnt;
  logic               w_tick;

  assign w_tick = en && (r_pre_cnt == C_LAST);
  assign tick   = w_tick;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pre_cnt <= '0;
    end else if (clr) begin
      r_pre_cnt <= '0;
    end else if (en) begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + C_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ghost_move_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ghost_move_ctrl
// Brief  : Game FSM, step pacing and movement of the ghost on the 8x16 grid.
// Rev    : 1.0 - initial release
// ============================================================================
module ghost_move_ctrl #(
  parameter int                            PRESCALE    = 1024,
  parameter logic [game_pkg::COORD_W-1:0]  START_COORD = game_pkg::START_COORD,
  parameter logic [1:0]                    START_DIR   = 2'b11
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           dir_valid,
  input  logic [1:0]                     dir,
  input  logic [14:0]                    delay,
  input  logic                           game_over,
  output logic [game_pkg::COORD_W-1:0]   nowCoord,
  output logic                           step_pulse,
  output logic                           dp_clear,
  output logic [1:0]                     state
);

  import game_pkg::*;

  localparam int C_DELAY_W = 15;

  state_t               r_state;
  state_t               w_state_nxt;
  dir_t                 r_cur_dir;
  dir_t                 r_pend_dir;
  dir_t                 w_dir_in;
  logic [COORD_W-1:0]   r_coord;
  logic [C_DELAY_W-1:0] r_delay_lat;
  logic [C_DELAY_W-1:0] r_tick_cnt;
  logic [C_DELAY_W-1:0] w_delay_eff;
  logic                 w_tick;
  logic                 w_pre_en;
  logic                 w_start_run;
  logic                 w_restart;
  logic                 w_run_active;
  logic                 w_step;
  logic                 w_dir_accept;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    case (r_state)
      IDLE: begin
        // A datapath still flagging game-over has not finished clearing.
        if (start && !game_over) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (game_over) begin
          w_state_nxt = OVER;
        end else if (pause) begin
          w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (game_over) begin
          w_state_nxt = OVER;
        end else if (pause) begin
          w_state_nxt = RUN;
        end
      end
      OVER: begin
        if (start) begin
          w_state_nxt = IDLE;
          w_restart   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_start_run  = (r_state == IDLE) && (w_state_nxt == RUN);
  assign w_run_active = (r_state == RUN) && !game_over;
  assign w_pre_en     = (r_state == RUN);

  // -------------------------------------------------------- step pacing
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_tick_prescaler (
    .clk  (clk),
    .rstn (rstn),
    .en   (w_pre_en),
    .clr  (w_start_run),
    .tick (w_tick)
  );

  assign w_delay_eff = (r_delay_lat == '0) ? C_DELAY_W'(1) : r_delay_lat;
  assign w_step      = w_run_active && w_tick
                       && (r_tick_cnt == (w_delay_eff - C_DELAY_W'(1)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tick_cnt  <= '0;
      r_delay_lat <= '0;
    end else begin
      // delay is only captured at interval boundaries, so edits land next interval.
      if (w_start_run || w_step) begin
        r_delay_lat <= delay;
      end
      if (w_start_run) begin
        r_tick_cnt <= '0;
      end else if (w_run_active && w_tick) begin
        r_tick_cnt <= w_step ? '0 : r_tick_cnt + C_DELAY_W'(1);
      end
    end
  end

  // ------------------------------------------------------ direction/move
  assign w_dir_in     = dir_t'(dir);
  assign w_dir_accept = dir_valid && ((r_state == RUN) || (r_state == PAUSE))
                        && !is_reverse(w_dir_in, r_cur_dir);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_coord    <= START_COORD;
      r_cur_dir  <= dir_t'(START_DIR);
      r_pend_dir <= dir_t'(START_DIR);
    end else if (w_restart) begin
      r_coord    <= START_COORD;
      r_cur_dir  <= dir_t'(START_DIR);
      r_pend_dir <= dir_t'(START_DIR);
    end else begin
      if (w_step) begin
        r_coord   <= move_coord(r_coord, r_pend_dir);
        r_cur_dir <= r_pend_dir;
      end
      // Old pend_dir is consumed by this step; a new command waits for the next one.
      if (w_dir_accept) begin
        r_pend_dir <= w_dir_in;
      end
    end
  end

  assign nowCoord   = r_coord;
  assign step_pulse = w_step;
  assign dp_clear   = w_restart;
  assign state      = r_state;

endmodule
`default_nettype wire
